// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states and access opcodes.
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/dmem_responder_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (wrapping) wins.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   logic [PTR_W:0] cand_s;
   logic           sel_s;

   // Scan candidates in rotated order; the first hit locks out later ones.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      any    = 1'b0;
      cand_s = '0;
      sel_s  = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand_s = {1'b0, ptr} + (PTR_W + 1)'(k);
         cand_s = (cand_s >= (PTR_W + 1)'(N)) ? cand_s - (PTR_W + 1)'(N) : cand_s;
         sel_s  = req[cand_s[PTR_W-1:0]] & ~any;
         idx    = sel_s ? cand_s[PTR_W-1:0] : idx;
         gnt[cand_s[PTR_W-1:0]] = gnt[cand_s[PTR_W-1:0]] | sel_s;
         any    = any | sel_s;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: round-robin arbitration over N_CORES request ports,
// one RAM access at a time, shared read-data bus and one-hot DONE pulse.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int N_CORES   = 4,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int MEM_DEPTH = 256,
   parameter int ACC_LAT   = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CORES-1:0]        MEMREAD,
   input  logic [N_CORES-1:0]        MEMWRITE,
   input  logic [N_CORES*ADDR_W-1:0] DMADDR,
   input  logic [N_CORES*DATA_W-1:0] DOUT,
   output logic [DATA_W-1:0]         DIN,
   output logic [N_CORES-1:0]        DONE,
   output logic                      BUSY
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int PTR_W = $clog2(N_CORES);
   localparam int CNT_W = $clog2(ACC_LAT) + 1;

   state_t               state_r;
   logic [PTR_W-1:0]     ptr_r;
   logic [PTR_W-1:0]     gid_r;
   logic [N_CORES-1:0]   gnt_oh_r;
   logic [N_CORES-1:0]   blackout_r;
   logic [IDX_W-1:0]     idx_r;
   logic [DATA_W-1:0]    wdata_r;
   op_t                  op_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [DATA_W-1:0]    mem_r [MEM_DEPTH];

   logic [N_CORES-1:0]   req_s;
   logic [N_CORES-1:0]   gnt_s;
   logic [PTR_W-1:0]     gnt_idx_s;
   logic                 gnt_any_s;
   logic                 last_s;

   // The just-served core sits out one IDLE cycle so it can drop its request.
   assign req_s  = (MEMREAD | MEMWRITE) & ~blackout_r;
   assign last_s = (cnt_r == CNT_W'(0));

   rr_arbiter #(
      .N     (N_CORES),
      .PTR_W (PTR_W)
   ) u_arb (
      .req (req_s),
      .ptr (ptr_r),
      .gnt (gnt_s),
      .idx (gnt_idx_s),
      .any (gnt_any_s)
   );

   // Request FSM: operands are captured at grant, so requesters may change after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         ptr_r      <= '0;
         gid_r      <= '0;
         gnt_oh_r   <= '0;
         blackout_r <= '0;
         idx_r      <= '0;
         wdata_r    <= '0;
         op_r       <= OP_RD;
         cnt_r      <= '0;
         DIN        <= '0;
         DONE       <= '0;
         BUSY       <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               blackout_r <= '0;
               if (gnt_any_s) begin
                  gid_r    <= gnt_idx_s;
                  gnt_oh_r <= gnt_s;
                  idx_r    <= DMADDR[ADDR_W*gnt_idx_s +: IDX_W];
                  wdata_r  <= DOUT[DATA_W*gnt_idx_s +: DATA_W];
                  op_r     <= MEMWRITE[gnt_idx_s] ? OP_WR : OP_RD;
                  cnt_r    <= CNT_W'(ACC_LAT - 1);
                  BUSY     <= 1'b1;
                  state_r  <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (last_s) begin
                  if (op_r == OP_RD) begin
                     DIN <= mem_r[idx_r];
                  end
                  DONE    <= gnt_oh_r;
                  state_r <= S_RESPOND;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            S_RESPOND: begin
               DONE       <= '0;
               BUSY       <= 1'b0;
               blackout_r <= gnt_oh_r;
               ptr_r      <= (gid_r == PTR_W'(N_CORES - 1)) ? '0 : gid_r + PTR_W'(1);
               state_r    <= S_IDLE;
            end
            default: begin
               DONE    <= '0;
               BUSY    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Word RAM, uninitialised; writes commit only on the final ACCESS edge.
   always_ff @(posedge clk) begin
      if (state_r == S_ACCESS && last_s && op_r == OP_WR) begin
         mem_r[idx_r] <= wdata_r;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single-core accesses plus
// hand-written reset-abort, contention and blackout sequences.
module tb_dmem_responder;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int AW  = 16;
   localparam int LAT = 2;   // ACC_LAT + 1
   localparam int GAP = 3;   // ACC_LAT + 2

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      mem_read;
   logic [N-1:0]      mem_write;
   logic [N*AW-1:0]   dmaddr;
   logic [N*DW-1:0]   dout;
   logic [DW-1:0]     din;
   logic [N-1:0]      done;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          core;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp_din;
   } vec_t;

   vec_t vecs [9];

   dmem_responder #(
      .N_CORES   (N),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .MEM_DEPTH (256),
      .ACC_LAT   (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .MEMREAD  (mem_read),
      .MEMWRITE (mem_write),
      .DMADDR   (dmaddr),
      .DOUT     (dout),
      .DIN      (din),
      .DONE     (done),
      .BUSY     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int c, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d);
      mem_read[c]          = rd;
      mem_write[c]         = wr;
      dmaddr[c*AW +: AW]   = a;
      dout[c*DW +: DW]     = d;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (done == '0 && cyc < 20);
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int cyc;
      set_req(v.core, v.rd, v.wr, v.addr, v.data);
      wait_done(cyc);
      check($sformatf("v%0d_done", k), 32'(done), 32'(1) << v.core);
      check($sformatf("v%0d_latency", k), 32'(cyc), 32'(LAT));
      check($sformatf("v%0d_din", k), 32'(din), 32'(v.exp_din));
      set_req(v.core, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      check($sformatf("v%0d_done_single", k), 32'(done), 32'h0);
      check($sformatf("v%0d_busy_idle", k), 32'(busy), 32'h0);
      tick();
   endtask

   initial begin
      int cyc;
      int ev;
      int last_cyc;
      int exp_core [5];
      logic [15:0] exp_rd [5];

      vecs[0] = '{core: 0, rd: 1'b0, wr: 1'b1, addr: 16'h0010, data: 16'hBEEF, exp_din: 16'h0000};
      vecs[1] = '{core: 0, rd: 1'b1, wr: 1'b0, addr: 16'h0010, data: 16'h0000, exp_din: 16'hBEEF};
      vecs[2] = '{core: 0, rd: 1'b1, wr: 1'b0, addr: 16'h0110, data: 16'h0000, exp_din: 16'hBEEF};
      vecs[3] = '{core: 1, rd: 1'b0, wr: 1'b1, addr: 16'h00FF, data: 16'h1357, exp_din: 16'hBEEF};
      vecs[4] = '{core: 1, rd: 1'b1, wr: 1'b0, addr: 16'h01FF, data: 16'h0000, exp_din: 16'h1357};
      vecs[5] = '{core: 2, rd: 1'b0, wr: 1'b1, addr: 16'h0005, data: 16'h0000, exp_din: 16'h1357};
      vecs[6] = '{core: 3, rd: 1'b1, wr: 1'b1, addr: 16'h0007, data: 16'h00AA, exp_din: 16'h1357};
      vecs[7] = '{core: 3, rd: 1'b1, wr: 1'b0, addr: 16'h0007, data: 16'h0000, exp_din: 16'h00AA};
      vecs[8] = '{core: 2, rd: 1'b1, wr: 1'b0, addr: 16'h0005, data: 16'h0000, exp_din: 16'h0000};

      mem_read  = '0;
      mem_write = '0;
      dmaddr    = '0;
      dout      = '0;
      rst_n     = 1'b0;
      tick();
      tick();
      check("rst_done", 32'(done), 32'h0);
      check("rst_din", 32'(din), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 9; k++) begin
         run_vec(vecs[k], k);
      end

      // Reset in the middle of a write: no DONE, no RAM update.
      set_req(2, 1'b0, 1'b1, 16'h0005, 16'h1234);
      tick();
      check("abort_busy_access", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_done", 32'(done), 32'h0);
      check("abort_din", 32'(din), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      set_req(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Contention from pointer 0; core0 keeps requesting after its first DONE.
      exp_core = '{0, 1, 2, 3, 0};
      exp_rd   = '{16'hBEEF, 16'h1357, 16'h0000, 16'h00AA, 16'hBEEF};
      set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      set_req(1, 1'b1, 1'b0, 16'h00FF, 16'h0000);
      set_req(2, 1'b1, 1'b0, 16'h0005, 16'h0000);
      set_req(3, 1'b1, 1'b0, 16'h0007, 16'h0000);
      ev       = 0;
      last_cyc = 0;
      for (int c = 1; c <= 40 && ev < 5; c++) begin
         tick();
         if (done != '0) begin
            check($sformatf("cont%0d_done", ev), 32'(done), 32'(1) << exp_core[ev]);
            check($sformatf("cont%0d_din", ev), 32'(din), 32'(exp_rd[ev]));
            if (ev > 0) begin
               check($sformatf("cont%0d_gap", ev), 32'(c - last_cyc), 32'(GAP));
            end
            last_cyc = c;
            if (ev != 0) begin
               set_req(exp_core[ev], 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            ev++;
         end
      end
      check("cont_events", 32'(ev), 32'd5);
      tick();
      tick();

      // Blackout: core1 holds its read straight through DONE.
      set_req(1, 1'b1, 1'b0, 16'h01FF, 16'h0000);
      wait_done(cyc);
      check("blk_first_done", 32'(done), 32'h2);
      check("blk_first_din", 32'(din), 32'h1357);
      tick();
      check("blk_idle1_busy", 32'(busy), 32'h0);
      tick();
      check("blk_idle2_busy", 32'(busy), 32'h0);
      wait_done(cyc);
      check("blk_regrant_done", 32'(done), 32'h2);
      check("blk_regrant_latency", 32'(cyc), 32'(LAT));
      set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
